// File: rtl/clk_div_meter.sv
// Measures high time, low time and period of a slow clock in clk_in cycles, with
// parity/balance flags, lock detection and a sticky timeout. dbg_state: 0 IDLE, 1 SYNC, 2 MEAS.
module clk_div_meter #(
  parameter int WIDTH    = 7,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] low_time,
  output logic [WIDTH:0]   period,
  output logic             meas_valid,
  output logic             odd_ratio,
  output logic             balanced,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       dbg_state
);
  // meas_valid is a one-cycle strobe with no ready/back-pressure: period,
  // high_time, low_time and the flags are stable from the strobe until the next one.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RUN_MAX  = '1;
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_s;
  logic             r_s_d;
  logic [WIDTH-1:0] r_hi_run;
  logic [WIDTH-1:0] r_lo_run;
  logic [3:0]       r_match_cnt;
  logic             r_first;
  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  logic             w_take_high;
  logic             w_take_meas;
  logic             w_timeout;
  logic [WIDTH:0]   w_period_new;
  logic [3:0]       w_match_next;

  assign w_rise       = r_s & ~r_s_d;
  assign w_fall       = ~r_s & r_s_d;
  assign w_sat        = (r_hi_run == RUN_MAX) || (r_lo_run == RUN_MAX);
  assign w_period_new = {1'b0, high_time} + {1'b0, r_lo_run};
  assign dbg_state    = r_state;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take_high  = 1'b0;
    w_take_meas  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_next = ST_SYNC;
      end
      ST_SYNC, ST_MEAS: begin
        // A saturated run counter wins over a coincident edge; that edge is dropped.
        if (w_sat) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_fall) begin
          w_take_high  = 1'b1;
          w_state_next = ST_MEAS;
        end else if (w_rise && (r_state == ST_MEAS)) begin
          w_take_meas  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The first period after SYNC is compared against a stale value, so it never counts.
  always_comb begin
    w_match_next = 4'd0;
    if (!r_first && (w_period_new == period)) begin
      w_match_next = (r_match_cnt >= LOCK_MAX) ? LOCK_MAX : r_match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_s         <= 1'b0;
      r_s_d       <= 1'b0;
      r_hi_run    <= '0;
      r_lo_run    <= '0;
      r_match_cnt <= 4'd0;
      r_first     <= 1'b0;
      high_time   <= '0;
      low_time    <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      odd_ratio   <= 1'b0;
      balanced    <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      r_sync1    <= div_clk;
      r_s        <= r_sync1;
      r_s_d      <= r_s;
      meas_valid <= 1'b0;

      if (w_timeout) begin
        r_hi_run <= '0;
        r_lo_run <= '0;
      end else if (r_s) begin
        if (r_hi_run != RUN_MAX) r_hi_run <= r_hi_run + 1'b1;
        if (w_rise) r_lo_run <= '0;
      end else begin
        if (r_lo_run != RUN_MAX) r_lo_run <= r_lo_run + 1'b1;
        if (w_fall) r_hi_run <= '0;
      end

      if (w_take_high) begin
        high_time <= r_hi_run;
        if (r_state == ST_SYNC) r_first <= 1'b1;
      end

      if (w_take_meas) begin
        low_time    <= r_lo_run;
        period      <= w_period_new;
        meas_valid  <= 1'b1;
        odd_ratio   <= w_period_new[0];
        balanced    <= (high_time == r_lo_run);
        timeout     <= 1'b0;
        r_match_cnt <= w_match_next;
        locked      <= (w_match_next >= LOCK_MAX);
        r_first     <= 1'b0;
      end

      if (w_timeout) begin
        timeout     <= 1'b1;
        locked      <= 1'b0;
        r_match_cnt <= 4'd0;
      end
    end
  end
endmodule

// File: doc/clk_div_meter.md
Name: clk_div_meter

Overview:
Receive-side companion to the team's even clock divider: measures a divided clock against the fast reference clock. Reports high time, low time and period in reference cycles, plus parity/balance flags and a lock indication once the ratio is stable. Sits beside any divider output, or on an external slow clock, for ratio checking and self-test.

Parameters:
WIDTH, 7, width of high/low run counters and of high_time/low_time; period is WIDTH+1 bits
LOCK_CNT, 3, number of consecutive matching periods required before locked asserts (1..15)

Ports:
clk_in  input  1  reference (fast) clock; all logic on posedge
rst  input  1  synchronous, active-high reset
div_clk  input  1  divided/slow clock under measurement, asynchronous to clk_in
high_time  output  WIDTH  last measured high run, in clk_in cycles
low_time  output  WIDTH  last measured low run, in clk_in cycles
period  output  WIDTH+1  last measured full period (high_time + low_time)
meas_valid  output  1  one-cycle pulse when period/high_time/low_time update
odd_ratio  output  1  period[0] of the last valid measurement
balanced  output  1  high_time == low_time for the last valid measurement
locked  output  1  ratio stable for LOCK_CNT consecutive periods
timeout  output  1  sticky: a run counter saturated; cleared by reset or next meas_valid

Behaviour:
- Reset: every output 0; synchronizer flops, run counters, match counter 0; FSM to IDLE.
- Input path: 2-flop synchronizer gives s; s_d is s delayed 1 cycle. Rise = s & ~s_d; fall = ~s & s_d. Edge on div_clk is detected 2-3 clk_in cycles later; measurements are relative to s, so latency does not bias them.
- Run counters: hi_run increments each cycle s==1; lo_run increments each cycle s==0; both saturate at all-ones.
- On fall: high_time <= hi_run; hi_run <= 0. On rise: lo_run <= 0.
- FSM states:
  - IDLE: ignore data, wait for a rise -> SYNC.
  - SYNC: first high phase in progress; on fall -> MEAS.
  - MEAS: on rise, update low_time <= lo_run and period <= high_time + lo_run (zero-extended to WIDTH+1); pulse meas_valid; stay in MEAS.
- No meas_valid before one complete high phase and one complete low phase have been seen after reset or timeout.
- Flags on meas_valid: odd_ratio <= period_new[0]; balanced <= (high_time == lo_run).
- Lock:
  - 4-bit match_cnt. On meas_valid: if period_new == period (previous), match_cnt increments, saturating at LOCK_CNT; otherwise match_cnt <= 0 and locked <= 0.
  - locked <= (match_cnt_next >= LOCK_CNT). The first measurement after IDLE never matches, so locked rises on the (LOCK_CNT+1)th meas_valid.
- Timeout:
  - Trigger: hi_run or lo_run equal to all-ones while still counting (any state except IDLE), i.e. a stuck or too-slow div_clk.
  - Action: timeout <= 1, locked <= 0, match_cnt <= 0, run counters 0, FSM -> IDLE.
  - high_time/low_time/period keep their last values. timeout clears on the next meas_valid.
- Simultaneous events: rise and fall cannot coincide (derived from a single s). A saturation on the same cycle as an edge is treated as timeout; the edge is discarded.
- Reset mid-measurement: aborts everything; no meas_valid until a fresh SYNC->MEAS sequence completes.
- Minimum measurable phase is 1 cycle. Divisors whose phases are shorter than the synchronizer resolution are outside the contract.

Test Plan:
- div_clk = clk_in/4 (2 high, 2 low), LOCK_CNT=3 -> meas_valid once per 4 cycles; high_time=2, low_time=2, period=4, odd_ratio=0, balanced=1; locked rises with the 4th meas_valid.
- div_clk high 3 / low 2 (divide-by-5) -> period=5, odd_ratio=1, balanced=0, high_time=3, low_time=2; locked after 4 valids.
- Locked at period 4, then switch to period 8 -> first 8-cycle meas_valid drops locked and reports period=8; relock on the 4th valid at period 8.
- div_clk held high, WIDTH=7 -> after hi_run reaches 127: timeout=1, locked=0, FSM IDLE, last period retained. Restarting toggling clears timeout at the next meas_valid.
- Assert rst for 1 cycle mid high phase while locked -> all outputs 0 the next cycle. The first meas_valid comes only after a full rise-fall-rise sequence.
- div_clk = clk_in/2 (1 high, 1 low) -> high_time=1, low_time=1, period=2, meas_valid every 2 cycles.
